// File: rtl/async_xing_pkg.sv
// Shared definitions for the toggle-handshake clock-domain crossing (source and sink sides).
package async_xing_pkg;

  localparam int unsigned SYNC_DEPTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/async_handshake_source_if.sv
// Bundle of the local enqueue port and the crossing-side req/data/ack signals.
interface async_handshake_source_if #(
  parameter int unsigned DATA_W = 32
);

  // Enqueue: a payload transfers on a clock edge where io_enq_valid and io_enq_ready are
  // both 1; the source raises io_enq_ready only when it can take a payload, and
  // io_enq_bits is looked at only on that edge. Crossing: io_req toggles once per payload,
  // io_data is stable whenever io_req is stable, and io_ack toggles back to match io_req.
  logic              io_enq_valid;
  logic              io_enq_ready;
  logic [DATA_W-1:0] io_enq_bits;
  logic              io_req;
  logic [DATA_W-1:0] io_data;
  logic              io_ack;
  logic              io_timeout;

  modport master (
    input  io_enq_valid,
    input  io_enq_bits,
    input  io_ack,
    output io_enq_ready,
    output io_req,
    output io_data,
    output io_timeout
  );

  modport slave (
    output io_enq_valid,
    output io_enq_bits,
    output io_ack,
    input  io_enq_ready,
    input  io_req,
    input  io_data,
    input  io_timeout
  );

endinterface

// File: rtl/ack_sync_shift_reg.sv
// Single-bit synchronizer: input enters the top stage, output is taken from stage 0.
module ack_sync_shift_reg #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {d_i, sync_q[DEPTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[0];

endmodule

// File: rtl/async_handshake_source.sv
// Source end of the toggle req/ack crossing. Define ASYNC_HANDSHAKE_SOURCE_TIMEOUT_EN to
// build the sticky BUSY-timeout counter; otherwise io_timeout is tied to 0.
module async_handshake_source
  import async_xing_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SYNC_DEPTH     = SYNC_DEPTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  async_handshake_source_if.master  io,
  output state_e                    dbg_state
);

  if (DATA_W < 1 || SYNC_DEPTH < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("async_handshake_source: illegal parameter value");
  end

  state_e            state_q;
  state_e            state_d;
  logic              req_q;
  logic              req_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              ack_sync;
  logic              enq_ready;
  logic              fire;

  // The only route from io_ack into local logic.
  ack_sync_shift_reg #(
    .DEPTH (SYNC_DEPTH)
  ) u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (io.io_ack),
    .q_o   (ack_sync)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = IDLE;
      IDLE:    if (fire) state_d = BUSY;
      BUSY:    if (ack_sync == req_q) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    enq_ready = (state_q == IDLE);
    fire      = enq_ready & io.io_enq_valid;
  end

  // req and data move together on fire only, which keeps data stable while req is.
  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    if (fire) begin
      req_d  = ~req_q;
      data_d = io.io_enq_bits;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
    end
  end

`ifdef ASYNC_HANDSHAKE_SOURCE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            timeout_q;
  logic            timeout_d;

  // Counts BUSY cycles of the current transfer; the flag stays set until reset.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (fire) begin
      cnt_d = '0;
    end else if (state_q == BUSY && cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (state_q == BUSY && cnt_d == CntMax) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign io.io_timeout = timeout_q;
`else
  assign io.io_timeout = 1'b0;
`endif

  assign io.io_enq_ready = enq_ready;
  assign io.io_req       = req_q;
  assign io.io_data      = data_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_async_handshake_source.sv
// Self-checking bench for async_handshake_source: table vectors, directed corner cases
// and a randomized loopback run against a cycle-count reference model.
module tb_async_handshake_source;
  import async_xing_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned LAT = 5;

  logic clk = 1'b0;
  logic clk2 = 1'b0;
  logic rst_n = 1'b0;
  logic enq_valid = 1'b0;
  logic [DW-1:0] enq_bits = '0;
  logic loop_en = 1'b1;
  logic ack_reg = 1'b0;
  state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic exp_req = 1'b0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          v;
    logic [DW-1:0] b;
    logic          rdy;
    logic          req;
    logic [DW-1:0] d;
  } vec_t;
  vec_t tbl[16];

  async_handshake_source_if #(.DATA_W(DW)) bus ();

  assign bus.io_enq_valid = enq_valid;
  assign bus.io_enq_bits  = enq_bits;
  assign bus.io_ack       = loop_en ? bus.io_req : ack_reg;

  async_handshake_source #(
    .DATA_W         (DW),
    .SYNC_DEPTH     (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock     (clk),
    .reset     (rst_n),
    .io        (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always begin
    #3 clk2 = 1'b1;
    #4 clk2 = 1'b0;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enq_valid = 1'b0;
    ack_reg = 1'b0;
    loop_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_req = 1'b0;
  endtask

  // driver: offer one payload at the negedge; returns after the following posedge (+1)
  task automatic drive(input logic v, input logic [DW-1:0] b);
    @(negedge clk);
    enq_valid = v;
    enq_bits = b;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [DW-1:0] b, input logic rdy,
                              input logic req, input logic [DW-1:0] d);
    vec_t r;
    r.v = v; r.b = b; r.rdy = rdy; r.req = req; r.d = d;
    return r;
  endfunction

  initial begin
    int rdy_at;
    int waited;
    logic prev_req;
    logic fire_m;
    logic v;
    logic [DW-1:0] b;
    logic [DW-1:0] held;
    logic exp_to;

    // ---- reset / INIT ----
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_req", bus.io_req, 0);
      chk("rst_data", bus.io_data, 0);
      chk("rst_ready", bus.io_enq_ready, 0);
      chk("rst_timeout", bus.io_timeout, 0);
      chk("rst_state", dbg_state, INIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("init_ready", bus.io_enq_ready, 0);
    @(posedge clk);
    #1;
    chk("idle_ready", bus.io_enq_ready, 1);

    // ---- loopback single transfer ----
    drive(1'b1, 32'hDEADBEEF);
    chk("single_data", bus.io_data, 32'hDEADBEEF);
    chk("single_req", bus.io_req, 1);
    chk("single_rdy1", bus.io_enq_ready, 0);
    for (int k = 2; k <= 5; k++) begin
      drive(1'b0, 32'h0);
      chk("single_rdy", bus.io_enq_ready, (k == 5) ? 1'b1 : 1'b0);
    end

    // ---- back-to-back table under loopback ----
    do_reset();
    tbl[0] = mk(1, 1, 0, 1, 1);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(1, 2, 0, 1, 1);
    tbl[4] = mk(1, 2, 1, 1, 1);
    tbl[5] = mk(1, 2, 0, 0, 2);
    for (int i = 6; i <= 8; i++) tbl[i] = mk(1, 3, 0, 0, 2);
    tbl[9] = mk(1, 3, 1, 0, 2);
    tbl[10] = mk(1, 3, 0, 1, 3);
    for (int i = 11; i <= 13; i++) tbl[i] = mk(0, 9, 0, 1, 3);
    tbl[14] = mk(0, 9, 1, 1, 3);
    tbl[15] = mk(0, 9, 1, 1, 3);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].b);
      chk("tbl_ready", bus.io_enq_ready, tbl[i].rdy);
      chk("tbl_req", bus.io_req, tbl[i].req);
      chk("tbl_data", bus.io_data, tbl[i].d);
    end
    exp_req = tbl[15].req;

    // ---- randomized loopback against cycle-count model + scoreboard ----
    rdy_at = 0;
    prev_req = exp_req;
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(0, 1));
      b = $urandom;
      fire_m = v && (i >= rdy_at);
      if (fire_m) begin
        exp_q.push_back(b);
        exp_req = ~exp_req;
        rdy_at = i + LAT;
      end
      drive(v, b);
      chk("rnd_ready", bus.io_enq_ready, (i + 1 >= rdy_at) ? 1'b1 : 1'b0);
      chk("rnd_req", bus.io_req, exp_req);
      if (bus.io_req !== prev_req) begin
        if (exp_q.size() > 0) chk("sb_data", bus.io_data, exp_q.pop_front());
        else chk("sb_extra", 1, 0);
        prev_req = bus.io_req;
      end
    end
    chk("sb_left", exp_q.size(), 0);
    repeat (LAT) drive(1'b0, 32'h0);

    // ---- delayed ack from unrelated clock ----
    loop_en = 1'b0;
    ack_reg = exp_req;
    held = 32'hCAFE0001;
    drive(1'b1, held);
    exp_req = ~exp_req;
    chk("dly_req", bus.io_req, exp_req);
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom);
      chk("dly_ready", bus.io_enq_ready, 0);
      chk("dly_data", bus.io_data, held);
    end
    enq_valid = 1'b0;
    @(posedge clk2);
    ack_reg = exp_req;
    waited = 0;
    while (bus.io_enq_ready !== 1'b1 && waited < 12) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("dly_ready_back", bus.io_enq_ready, 1);
    chk("dly_wait_ok", (waited >= 3 && waited <= 6) ? 1 : 0, 1);
    chk("dly_req_hold", bus.io_req, exp_req);

    // ---- timeout: never ack, then a late ack ----
`ifdef ASYNC_HANDSHAKE_SOURCE_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    drive(1'b1, 32'h77);
    exp_req = ~exp_req;
    chk("to_start", bus.io_timeout, 0);
    for (int k = 1; k <= 26; k++) begin
      drive(1'b0, 32'h0);
      chk("to_flag", bus.io_timeout, (k >= 16) ? exp_to : 1'b0);
      chk("to_ready", bus.io_enq_ready, 0);
    end
    ack_reg = exp_req;
    waited = 0;
    while (bus.io_enq_ready !== 1'b1 && waited < 10) begin
      drive(1'b0, 32'h0);
      waited++;
    end
    chk("to_late_ready", bus.io_enq_ready, 1);
    chk("to_sticky", bus.io_timeout, exp_to);

    // ---- mid-transfer reset, then fresh transfer ----
    loop_en = 1'b1;
    drive(1'b1, 32'hA5A5A5A5);
    exp_req = ~exp_req;
    chk("mid_busy", bus.io_enq_ready, 0);
    enq_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ack_reg = 1'b0;
    #1;
    chk("mid_req", bus.io_req, 0);
    chk("mid_data", bus.io_data, 0);
    chk("mid_ready", bus.io_enq_ready, 0);
    chk("mid_timeout", bus.io_timeout, 0);
    chk("mid_state", dbg_state, INIT);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_req = 1'b0;
    chk("mid_idle", bus.io_enq_ready, 1);
    drive(1'b1, 32'h5);
    chk("post_data", bus.io_data, 32'h5);
    chk("post_req", bus.io_req, 1);
    for (int k = 2; k <= 5; k++) begin
      drive(1'b0, 32'h0);
      chk("post_ready", bus.io_enq_ready, (k == 5) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
